// File: rtl/change_dispenser.sv
// change_dispenser
//   Payout end of the vend path. Accepts a change amount and pays it out as
//   10c and 5c coins, pulsing the hopper eject solenoids and waiting for the
//   coin-sensor acknowledge for each coin. Tracks the coin inventory and
//   raises sticky shortage / jam faults.
//
//   Optional feature: define CHANGE_DISP_PRECHECK_EN for all-or-nothing
//   payout. The first CHECK of each request then verifies that the whole
//   amount is payable greedily before any coin is ejected.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   change request handshake
//   req_amount            change to pay in cents (mod-5 remainder dropped)
//   eject10, eject5       solenoid pulses, PULSE_CYC cycles wide
//   hopper_ack            one-cycle coin-left-hopper pulse
//   load10, load5         load inventory from load_val (IDLE only)
//   inv10, inv5           remaining coin counts
//   busy                  high in CHECK / EJECT / WAIT_ACK
//   done                  one-cycle pulse when the amount has been paid
//   short_fault           sticky: amount not payable from inventory
//   jam_fault             sticky: hopper_ack timed out
//   fault_clr             clears both faults and returns to IDLE
module change_dispenser #(
  parameter int AMT_W     = 6,
  parameter int INV_W     = 8,
  parameter int PULSE_CYC = 4,
  parameter int ACK_TMO   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  output logic             eject10,
  output logic             eject5,
  input  logic             hopper_ack,
  input  logic             load10,
  input  logic             load5,
  input  logic [INV_W-1:0] load_val,
  output logic [INV_W-1:0] inv10,
  output logic [INV_W-1:0] inv5,
  output logic             busy,
  output logic             done,
  output logic             short_fault,
  output logic             jam_fault,
  input  logic             fault_clr
);

  localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam int TW = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_EJECT, S_WAIT_ACK, S_DONE, S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [INV_W-1:0] inv10_q, inv10_d, inv5_q, inv5_d;
  logic             sel10_q, sel10_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             ack_seen_q, ack_seen_d;
  logic             short_q, short_d, jam_q, jam_d;

`ifdef CHANGE_DISP_PRECHECK_EN
  localparam int CW = ((AMT_W > INV_W) ? AMT_W : INV_W) + 4;
  logic          first_q, first_d;
  logic [CW-1:0] pc_q10, pc_n10, pc_left5;
  logic          payable;

  // Greedy feasibility: take as many 10c as possible, rest must fit in 5c.
  always_comb begin
    pc_q10   = CW'(rem_q) / CW'(10);
    pc_n10   = (pc_q10 < CW'(inv10_q)) ? pc_q10 : CW'(inv10_q);
    pc_left5 = (CW'(rem_q) - pc_n10 * CW'(10)) / CW'(5);
    payable  = (pc_left5 <= CW'(inv5_q));
  end
`endif

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    inv10_d    = inv10_q;
    inv5_d     = inv5_q;
    sel10_d    = sel10_q;
    pcnt_d     = pcnt_q;
    tcnt_d     = tcnt_q;
    ack_seen_d = ack_seen_q;
    short_d    = short_q;
    jam_d      = jam_q;
`ifdef CHANGE_DISP_PRECHECK_EN
    first_d    = first_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load10) inv10_d = load_val;
        if (load5)  inv5_d  = load_val;
        if (req_valid) begin
          rem_d   = req_amount - (req_amount % AMT_W'(5));
          state_d = S_CHECK;
`ifdef CHANGE_DISP_PRECHECK_EN
          first_d = 1'b1;
`endif
        end
      end
      S_CHECK: begin
`ifdef CHANGE_DISP_PRECHECK_EN
        first_d = 1'b0;
`endif
        if (rem_q == '0) begin
          state_d = S_DONE;
`ifdef CHANGE_DISP_PRECHECK_EN
        end else if (first_q && !payable) begin
          state_d = S_FAULT;
          short_d = 1'b1;
          rem_d   = '0;
`endif
        end else if (rem_q >= AMT_W'(10) && inv10_q != '0) begin
          sel10_d    = 1'b1;
          pcnt_d     = '0;
          ack_seen_d = 1'b0;
          state_d    = S_EJECT;
        end else if (rem_q >= AMT_W'(5) && inv5_q != '0) begin
          sel10_d    = 1'b0;
          pcnt_d     = '0;
          ack_seen_d = 1'b0;
          state_d    = S_EJECT;
        end else begin
          state_d = S_FAULT;
          short_d = 1'b1;
          rem_d   = '0;
        end
      end
      S_EJECT: begin
        // A fast sensor may report the coin before the pulse ends; remember it.
        if (hopper_ack) ack_seen_d = 1'b1;
        if (pcnt_q == P_LAST) begin
          tcnt_d  = '0;
          state_d = S_WAIT_ACK;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      S_WAIT_ACK: begin
        if (hopper_ack || ack_seen_q) begin
          if (sel10_q) begin
            inv10_d = inv10_q - INV_W'(1);
            rem_d   = rem_q - AMT_W'(10);
          end else begin
            inv5_d = inv5_q - INV_W'(1);
            rem_d  = rem_q - AMT_W'(5);
          end
          ack_seen_d = 1'b0;
          state_d    = S_CHECK;
        end else if (tcnt_q == T_LAST) begin
          jam_d   = 1'b1;
          rem_d   = '0;
          state_d = S_FAULT;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      S_FAULT: begin
        if (fault_clr) begin
          short_d = 1'b0;
          jam_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      inv10_q    <= '0;
      inv5_q     <= '0;
      sel10_q    <= 1'b0;
      pcnt_q     <= '0;
      tcnt_q     <= '0;
      ack_seen_q <= 1'b0;
      short_q    <= 1'b0;
      jam_q      <= 1'b0;
`ifdef CHANGE_DISP_PRECHECK_EN
      first_q    <= 1'b0;
`endif
      eject10    <= 1'b0;
      eject5     <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      inv10_q    <= inv10_d;
      inv5_q     <= inv5_d;
      sel10_q    <= sel10_d;
      pcnt_q     <= pcnt_d;
      tcnt_q     <= tcnt_d;
      ack_seen_q <= ack_seen_d;
      short_q    <= short_d;
      jam_q      <= jam_d;
`ifdef CHANGE_DISP_PRECHECK_EN
      first_q    <= first_d;
`endif
      eject10    <= (state_d == S_EJECT) && sel10_d;
      eject5     <= (state_d == S_EJECT) && !sel10_d;
      req_ready  <= (state_d == S_IDLE);
      busy       <= (state_d inside {S_CHECK, S_EJECT, S_WAIT_ACK});
      done       <= (state_d == S_DONE);
    end
  end

  assign inv10       = inv10_q;
  assign inv5        = inv5_q;
  assign short_fault = short_q;
  assign jam_fault   = jam_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser. Stimulus pushes expected output
// events (eject pulses with width, done / fault with inventory snapshot);
// a monitor pops and compares each event the DUT presents.
module tb_change_dispenser;
  localparam int AMT_W = 6, INV_W = 8, PULSE_CYC = 4, ACK_TMO = 64;
  localparam int K_E10 = 0, K_E5 = 1, K_DONE = 2, K_SHORT = 3, K_JAM = 4;

  logic clk, rst_n, req_valid, req_ready, eject10, eject5, hopper_ack;
  logic load10, load5, busy, done, short_fault, jam_fault, fault_clr;
  logic [AMT_W-1:0] req_amount;
  logic [INV_W-1:0] load_val, inv10, inv5;

  change_dispenser #(.AMT_W(AMT_W), .INV_W(INV_W), .PULSE_CYC(PULSE_CYC), .ACK_TMO(ACK_TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_amount(req_amount), .eject10(eject10), .eject5(eject5),
    .hopper_ack(hopper_ack), .load10(load10), .load5(load5), .load_val(load_val),
    .inv10(inv10), .inv5(inv5), .busy(busy), .done(done),
    .short_fault(short_fault), .jam_fault(jam_fault), .fault_clr(fault_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int kind; int a; int b;} ev_t;
  ev_t exp_q[$];
  int  total = 0, bad = 0;

  int ack_dly = 2;
  bit ack_en = 1'b1, ack_early = 1'b0;
  int ack_cnt = 0;
  bit ack_prev = 1'b0;

  int w10 = 0, w5 = 0, since = 0;
  bit p10 = 0, p5 = 0, pdone = 0, psh = 0, pjam = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int k, input int a, input int b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int k, input int a, input int b);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL ev_unexpected: got kind=%0d a=%0d b=%0d expected none", k, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b) begin
        bad++;
        $display("FAIL ev_scoreboard: got kind=%0d a=%0d b=%0d expected kind=%0d a=%0d b=%0d",
                 k, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events for the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        w10 = 0; w5 = 0; since = 0;
        p10 = 0; p5 = 0; pdone = 0; psh = 0; pjam = 0;
      end else begin
        if (eject10 || eject5) begin
          total++;
          if (eject10 && eject5) begin
            bad++;
            $display("FAIL eject_excl: got both high expected one");
          end
        end
        since++;
        if (eject10) w10++;
        else if (p10) begin observe(K_E10, w10, 0); w10 = 0; since = 0; end
        if (eject5) w5++;
        else if (p5) begin observe(K_E5, w5, 0); w5 = 0; since = 0; end
        if (done && !pdone)       observe(K_DONE, int'(inv10), int'(inv5));
        if (short_fault && !psh)  observe(K_SHORT, int'(inv10), int'(inv5));
        if (jam_fault && !pjam)   observe(K_JAM, since, int'(inv10));
        p10 = eject10; p5 = eject5; pdone = done; psh = short_fault; pjam = jam_fault;
      end
    end
  end

  // Hopper model: acks ack_dly cycles after the pulse ends, or during the
  // pulse when ack_early is set.
  initial begin
    hopper_ack = 1'b0;
    forever begin
      @(negedge clk);
      hopper_ack = 1'b0;
      if (!rst_n) begin
        ack_cnt = 0; ack_prev = 1'b0;
      end else begin
        if (ack_cnt > 0) begin
          ack_cnt--;
          if (ack_cnt == 0) hopper_ack = 1'b1;
        end
        if (ack_en && !ack_early && ack_prev && !(eject10 || eject5)) begin
          if (ack_dly <= 1) hopper_ack = 1'b1;
          else ack_cnt = ack_dly - 1;
        end
        if (ack_en && ack_early && !ack_prev && (eject10 || eject5)) hopper_ack = 1'b1;
        ack_prev = eject10 || eject5;
      end
    end
  end

  function automatic logic sel_sig(input int which);
    case (which)
      0: return req_ready;
      1: return eject10;
      2: return eject5;
      3: return short_fault;
      4: return jam_fault;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input logic val, input int budget);
    int n = 0;
    while (sel_sig(which) !== val && n < budget) begin @(negedge clk); n++; end
    chk({"wait_", name}, int'(n < budget), 1);
  endtask

  task automatic drain(input string name, input bit need_ready, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || (need_ready && req_ready !== 1'b1)) && n < budget) begin
      @(negedge clk); n++;
    end
    chk({"drain_", name}, int'(n < budget), 1);
  endtask

  task automatic do_req(input int amt);
    wait_for("ready", 0, 1'b1, 400);
    req_valid = 1'b1; req_amount = AMT_W'(amt);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic load_inv(input int v10, input int v5);
    wait_for("ready_ld", 0, 1'b1, 400);
    load10 = 1'b1; load_val = INV_W'(v10);
    @(negedge clk);
    load10 = 1'b0; load5 = 1'b1; load_val = INV_W'(v5);
    @(negedge clk);
    load5 = 1'b0;
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_amount = '0; load10 = 1'b0; load5 = 1'b0;
    load_val = '0; fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ej10", eject10, 0);
    chk("rst_ej5", eject5, 0);
    chk("rst_inv10", inv10, 0);
    chk("rst_inv5", inv5, 0);
    chk("rst_short", short_fault, 0);
    chk("rst_jam", jam_fault, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 15c from full inventory: one 10c then one 5c
    load_inv(5, 5);
    chk("load_inv10", inv10, 5);
    chk("load_inv5", inv5, 5);
    ack_dly = 3;
    expect_ev(K_E10, 4, 0); expect_ev(K_E5, 4, 0); expect_ev(K_DONE, 4, 4);
    do_req(15);
    drain("15c", 1'b1, 400);

    // 30c with a single 10c: greedy falls back to four 5c
    load_inv(1, 5);
    expect_ev(K_E10, 4, 0);
    for (int i = 0; i < 4; i++) expect_ev(K_E5, 4, 0);
    expect_ev(K_DONE, 0, 1);
    do_req(30);
    drain("30c", 1'b1, 600);

    // 10c with no 10c coins: paid as 5c+5c
    ack_dly = 2;
    load_inv(0, 3);
    expect_ev(K_E5, 4, 0); expect_ev(K_E5, 4, 0); expect_ev(K_DONE, 0, 1);
    do_req(10);
    drain("10as5", 1'b1, 400);

    // Shortage: 15c with only one 5c
    load_inv(0, 1);
`ifdef CHANGE_DISP_PRECHECK_EN
    expect_ev(K_SHORT, 0, 1);
`else
    expect_ev(K_E5, 4, 0); expect_ev(K_SHORT, 0, 0);
`endif
    do_req(15);
    wait_for("short", 3, 1'b1, 200);
    drain("short", 1'b0, 50);
    chk("short_ready", req_ready, 0);
    chk("short_busy", busy, 0);
    pulse_clr();
    chk("short_clr", short_fault, 0);
    chk("short_clr_ready", req_ready, 1);

    // Jam: no ack at all
    load_inv(2, 0);
    ack_en = 1'b0;
    expect_ev(K_E10, 4, 0); expect_ev(K_JAM, ACK_TMO, 2);
    do_req(10);
    wait_for("jam", 4, 1'b1, 300);
    drain("jam", 1'b0, 50);
    chk("jam_inv10", inv10, 2);
    chk("jam_ready", req_ready, 0);
    pulse_clr();
    chk("jam_clr", jam_fault, 0);
    chk("jam_clr_ready", req_ready, 1);
    ack_en = 1'b1;

    // 0c and 3c: done straight after CHECK
    load_inv(2, 2);
    expect_ev(K_DONE, 2, 2);
    do_req(0);
    chk("z_busy", busy, 1);
    @(negedge clk);
    chk("z_done_lat", done, 1);
    drain("0c", 1'b1, 50);
    expect_ev(K_DONE, 2, 2);
    do_req(3);
    @(negedge clk);
    chk("r3_done_lat", done, 1);
    drain("3c", 1'b1, 50);

    // load5 during WAIT_ACK is ignored
    ack_dly = 6;
    expect_ev(K_E5, 4, 0); expect_ev(K_DONE, 2, 1);
    do_req(5);
    wait_for("e5_hi", 2, 1'b1, 50);
    wait_for("e5_lo", 2, 1'b0, 50);
    load5 = 1'b1; load_val = 8'd9;
    @(negedge clk);
    load5 = 1'b0;
    drain("ld_wait", 1'b1, 100);
    chk("ld_wait_inv5", inv5, 1);
    ack_dly = 2;

    // Ack arrives during the pulse: pulse still full width, counted once
    ack_early = 1'b1;
    expect_ev(K_E10, 4, 0); expect_ev(K_DONE, 1, 1);
    do_req(10);
    drain("early", 1'b1, 100);
    ack_early = 1'b0;

    // Reset mid-pulse
    load_inv(1, 1);
    do_req(10);
    wait_for("rst_ej", 1, 1'b1, 50);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ej10", eject10, 0);
    chk("mid_rst_inv10", inv10, 0);
    chk("mid_rst_inv5", inv5, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_short", short_fault, 0);
    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
